switch_input_port: RTL and testbench
====================================

// Module: switch_input_port
// PURPOSE
//  Memory-mapped switch/button input peripheral; the CPU core's LW path reads switch data from it.
//  - Synchronises the board switches and a commit button, and debounces the button.
//  - On each debounced button press, captures the switch word into a data register and raises a ready flag.
//  - Returns that word or a status word combinationally on SWData, selected by read_address.
// PARAMETERS
//  SW_WIDTH   16        number of switch inputs (1..31)
//  DB_LIMIT   1000000   cycles btn must be stable before its debounced level changes (>=2)
//  ADDR_DATA  16'h8000  data register address
//  ADDR_STAT  16'h8001  status register address
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  rst           in   1         synchronous, active-high reset
//  sw            in   SW_WIDTH  raw switch levels (asynchronous)
//  btn_commit    in   1         raw commit button (asynchronous, bouncy)
//  read_address  in   16        CPU load address (MEM stage)
//  read_enable   in   1         CPU load strobe, one cycle per LW to this block
//  SWData        out  32        read data, combinational from read_address
//  ready_led     out  1         copy of ready flag
// BEHAVIOUR
//  Clock and reset:
//  - One clock domain. Reset is synchronous and active-high; it wins over every other event.
//  - Reset clears sw/btn 2-flop synchronisers, btn_db, db_cnt, data_reg, ready and overrun. After reset: SWData=0, ready_led=0.
//  Synchronisation:
//  - sw and btn_commit each pass through 2 flops, giving sw_s and btn_s.
//  - Switches are not debounced; the user sets them before pressing the button.
//  Debounce ($clog2(DB_LIMIT)-bit counter db_cnt):
//  - btn_s==btn_db: db_cnt<=0.
//  - btn_s!=btn_db and db_cnt<DB_LIMIT-1: db_cnt<=db_cnt+1.
//  - btn_s!=btn_db and db_cnt==DB_LIMIT-1: btn_db<=btn_s, db_cnt<=0.
//  - Any bounce back to btn_db before the limit restarts the count.
//  Capture (commit):
//  - Happens on the edge where btn_db goes 0->1: data_reg<=sw_s, ready<=1.
//  - If ready was already 1 and no data read occurs in the same cycle, overrun<=1 and the old data is overwritten.
//  - A 1->0 btn_db transition has no side effect.
//  - Latency: counting the first edge that samples btn_commit=1 (held stable) as edge 1, ready is high after edge DB_LIMIT+2.
//  Read path (combinational, no latency; the CPU samples SWData on the edge ending the read_enable cycle):
//  - read_address==ADDR_DATA: SWData = extended data_reg.
//  - read_address==ADDR_STAT: SWData = {30'b0, overrun, ready}.
//  - Any other address: SWData = 32'b0.
//  - SWData does not depend on read_enable.
//  Side effects:
//  - read_enable=1 with address ADDR_DATA clears ready and overrun at the edge.
//  - A status read has no side effect.
//  - read_enable with any other address is ignored.
//  Simultaneous events:
//  - Commit and data read in the same cycle: the read returns the old data_reg. At the edge, data_reg takes the new value, ready stays 1, overrun<=0.
//  - Reset during a debounce count, or with ready=1, discards all pending state.
// CONFIGURATION
//  SWIN_SIGN_EXT_EN
//  - Defined: data word = data_reg sign-extended from bit SW_WIDTH-1.
//  - Undefined (default): data word = {(32-SW_WIDTH)'b0, data_reg} (zero-extended).
// TESTING (SW_WIDTH=16, DB_LIMIT=4)
//  1 Reset:
//    rst=1 for 2 cycles with sw=16'hFFFF and btn=1 -> SWData=0 at both addresses; ready_led=0; no capture until DB_LIMIT+2 edges after release of rst.
//  2 Clean press:
//    sw=16'h1234, btn 0->1 and held -> ready_led rises after edge 6.
//    Read 0x8000 -> SWData=32'h00001234.
//    Read 0x8001 before the data read -> 32'h1.
//  3 Bounce:
//    btn toggles 1,0,1,0 on consecutive cycles, then held high -> exactly one capture, 6 edges after the final rise.
//    No capture during the toggling.
//  4 Overrun:
//    Commit 16'h00AA, then commit 16'h0055 with no read -> status=32'h3, data=32'h00000055.
//    LW of 0x8000 with read_enable -> status then reads 32'h0.
//  5 Simultaneous commit and data read:
//    Commit edge coincides with a read_enable cycle at 0x8000 -> read returns old data; afterwards status=32'h1 and data=new value.
//  6 Sign extension:
//    sw=16'h8001, commit, read 0x8000 -> 32'h00008001 without SWIN_SIGN_EXT_EN; 32'hFFFF8001 with it.
//    Read of 0x7FFF -> 32'h0.

Source files
------------

// File: rtl/switch_input_port.sv
// Memory-mapped switch/commit-button input port: synchronises and debounces inputs, captures the switch word on a press.
// Optional macro SWIN_SIGN_EXT_EN sign-extends the data word from bit SW_WIDTH-1 (zero-extended when undefined).
module switch_input_port #(
   parameter int          SW_WIDTH  = 16,
   parameter int          DB_LIMIT  = 1000000,
   parameter logic [15:0] ADDR_DATA = 16'h8000,
   parameter logic [15:0] ADDR_STAT = 16'h8001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                btn_commit,
   input  logic [15:0]         read_address,
   input  logic                read_enable,
   output logic [31:0]         SWData,
   output logic                ready_led
);

   localparam int            CW       = $clog2(DB_LIMIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_s;
   logic                btn_meta;
   logic                btn_s;
   logic                btn_db;
   logic [CW-1:0]       db_cnt;
   logic [SW_WIDTH-1:0] data_reg;
   logic                ready;
   logic                overrun;
   logic [31:0]         data_word;

   // Read strobe: read_enable is a one-cycle LW strobe with no back-pressure; the
   // CPU samples SWData on the edge ending that cycle, which is also when a data
   // read consumes the ready flag.
   logic data_rd;
   logic commit;

   assign data_rd = read_enable && (read_address == ADDR_DATA);
   assign commit  = btn_s && !btn_db && (db_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta  <= '0;
         sw_s     <= '0;
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         btn_db   <= 1'b0;
         db_cnt   <= '0;
         data_reg <= '0;
         ready    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         sw_meta  <= sw;
         sw_s     <= sw_meta;
         btn_meta <= btn_commit;
         btn_s    <= btn_meta;

         if (btn_s == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end

         // A same-cycle data read has already returned the old word, so it counts as consumed.
         if (commit) begin
            data_reg <= sw_s;
            ready    <= 1'b1;
            overrun  <= ready && !data_rd;
         end else if (data_rd) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

`ifdef SWIN_SIGN_EXT_EN
   assign data_word = {{(32-SW_WIDTH){data_reg[SW_WIDTH-1]}}, data_reg};
`else
   assign data_word = {{(32-SW_WIDTH){1'b0}}, data_reg};
`endif

   always_comb begin
      SWData = 32'h0;
      if (read_address == ADDR_DATA) begin
         SWData = data_word;
      end else if (read_address == ADDR_STAT) begin
         SWData = {30'h0, overrun, ready};
      end
   end

   assign ready_led = ready;

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port (SW_WIDTH=16, DB_LIMIT=4): directed scenarios plus random traffic.
module tb_switch_input_port;

   localparam int          SW_W   = 16;
   localparam int          DBL    = 4;
   localparam logic [15:0] A_DATA = 16'h8000;
   localparam logic [15:0] A_STAT = 16'h8001;

   logic            clk = 1'b0;
   logic            rst;
   logic [SW_W-1:0] sw;
   logic            btn;
   logic [15:0]     read_address;
   logic            read_enable;
   logic [31:0]     SWData;
   logic            ready_led;

   int errors = 0;
   int checks = 0;

   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   switch_input_port #(
      .SW_WIDTH (SW_W),
      .DB_LIMIT (DBL),
      .ADDR_DATA(A_DATA),
      .ADDR_STAT(A_STAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .btn_commit  (btn),
      .read_address(read_address),
      .read_enable (read_enable),
      .SWData      (SWData),
      .ready_led   (ready_led)
   );

   // Reference model: inputs delayed two edges, a run-length debouncer, and the commit/read rules.
   logic            m_ready = 1'b0;
   logic            m_ovr   = 1'b0;
   logic [SW_W-1:0] m_data  = '0;
   logic            m_db    = 1'b0;
   int              m_run   = 0;
   logic            bq[$];
   logic [SW_W-1:0] sq[$];

   function automatic logic [31:0] ext(input logic [SW_W-1:0] d);
`ifdef SWIN_SIGN_EXT_EN
      return {{(32-SW_W){d[SW_W-1]}}, d};
`else
      return {{(32-SW_W){1'b0}}, d};
`endif
   endfunction

   function automatic logic [31:0] model_word(input logic [15:0] a);
      if (a == A_DATA) return ext(m_data);
      if (a == A_STAT) return {30'h0, m_ovr, m_ready};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      logic            bs;
      logic [SW_W-1:0] ss;
      logic            rd;
      logic            cm;
      if (rst) begin
         bq = '{1'b0, 1'b0};
         sq = '{16'h0, 16'h0};
         m_ready = 1'b0; m_ovr = 1'b0; m_data = '0; m_db = 1'b0; m_run = 0;
      end else begin
         bs = bq.pop_front(); bq.push_back(btn);
         ss = sq.pop_front(); sq.push_back(sw);
         rd = read_enable && (read_address == A_DATA);
         cm = 1'b0;
         if (bs != m_db) begin
            m_run++;
            if (m_run == DBL) begin
               m_db  = bs;
               m_run = 0;
               cm    = bs;
            end
         end else begin
            m_run = 0;
         end
         if (cm) begin
            m_ovr   = rd ? 1'b0 : (m_ready ? 1'b1 : m_ovr);
            m_ready = 1'b1;
            m_data  = ss;
         end else if (rd) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
         end
      end
   end

   // Monitor: every driven cycle leaves one expected {ready_led, SWData} pair.
   always @(negedge clk) begin
      logic [32:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({ready_led, SWData} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t addr=%h got rdy=%b data=%h exp rdy=%b data=%h",
                     $time, read_address, ready_led, SWData, e[32], e[31:0]);
         end
      end
   end

   task automatic cycle(input logic [15:0] a, input logic en);
      @(posedge clk);
      #1;
      read_address = a;
      read_enable  = en;
      exp_q.push_back({m_ready, model_word(a)});
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(A_STAT, 1'b0);
   endtask

   task automatic check_now(input string name, input logic [15:0] a, input logic [31:0] expv);
      logic [15:0] saved;
      saved = read_address;
      read_address = a;
      #1;
      checks++;
      if (SWData !== expv) begin
         errors++;
         $display("FAIL %s addr=%h got %h exp %h", name, a, SWData, expv);
      end
      read_address = saved;
      #1;
   endtask

   task automatic check_rise(input string name, input int exp_edges);
      int  k;
      bit  found;
      k = 0;
      found = 1'b0;
      while (!found && k < 20) begin
         cycle(A_STAT, 1'b0);
         k++;
         if (ready_led) found = 1'b1;
      end
      checks++;
      if (!found || k != exp_edges) begin
         errors++;
         $display("FAIL %s ready rose after edge %0d (found=%0b) exp edge %0d", name, k, found, exp_edges);
      end
   endtask

   task automatic press_release(input logic [SW_W-1:0] v);
      sw  = v;
      btn = 1'b1;
      idle(8);
      btn = 1'b0;
      idle(8);
   endtask

   initial begin
      logic [15:0] a;
      int          hold;
      rst = 1'b1; sw = 16'hFFFF; btn = 1'b1;
      read_address = A_STAT; read_enable = 1'b0;

      // Reset with inputs active, then the held button commits DB_LIMIT+2 edges later.
      idle(2);
      rst = 1'b0;
      check_now("reset_data", A_DATA, 32'h0);
      check_now("reset_stat", A_STAT, 32'h0);
      checks++;
      if (ready_led !== 1'b0) begin
         errors++;
         $display("FAIL reset_led got %b exp 0", ready_led);
      end
      check_rise("post_reset_rise", DBL + 2);
      check_now("post_reset_data", A_DATA, ext(16'hFFFF));
      cycle(A_DATA, 1'b1);
      btn = 1'b0;
      idle(8);

      // Clean press.
      sw = 16'h1234; btn = 1'b1;
      check_rise("clean_rise", DBL + 2);
      check_now("clean_stat", A_STAT, 32'h1);
      check_now("clean_data", A_DATA, 32'h00001234);
      cycle(A_DATA, 1'b1);
      idle(1);
      check_now("clean_cleared", A_STAT, 32'h0);
      btn = 1'b0;
      idle(8);

      // Bounce 1,0,1,0 then hold high.
      sw = 16'h0F0F;
      btn = 1'b1; cycle(A_STAT, 1'b0);
      btn = 1'b0; cycle(A_STAT, 1'b0);
      btn = 1'b1; cycle(A_STAT, 1'b0);
      btn = 1'b0; cycle(A_STAT, 1'b0);
      btn = 1'b1;
      check_rise("bounce_rise", DBL + 2);
      check_now("bounce_data", A_DATA, 32'h00000F0F);
      cycle(A_DATA, 1'b1);
      btn = 1'b0;
      idle(8);

      // Overrun.
      press_release(16'h00AA);
      press_release(16'h0055);
      check_now("ovr_stat", A_STAT, 32'h3);
      check_now("ovr_data", A_DATA, 32'h00000055);
      cycle(A_DATA, 1'b1);
      idle(1);
      check_now("ovr_cleared", A_STAT, 32'h0);

      // Commit coinciding with a data read.
      press_release(16'h0AAA);
      sw = 16'h0BBB; btn = 1'b1;
      idle(4);
      cycle(A_DATA, 1'b1);
      check_now("simul_old_data", A_DATA, 32'h00000AAA);
      idle(1);
      check_now("simul_stat", A_STAT, 32'h1);
      check_now("simul_new_data", A_DATA, 32'h00000BBB);
      cycle(A_DATA, 1'b1);
      btn = 1'b0;
      idle(8);

      // Extension of the top switch bit and an unmapped address.
      press_release(16'h8001);
`ifdef SWIN_SIGN_EXT_EN
      check_now("ext_data", A_DATA, 32'hFFFF8001);
`else
      check_now("ext_data", A_DATA, 32'h00008001);
`endif
      check_now("unmapped", 16'h7FFF, 32'h0);
      cycle(A_DATA, 1'b1);

      // Random traffic, including occasional reset and bouncy button.
      hold = 0;
      repeat (1500) begin
         rst = ($urandom_range(0, 99) == 0);
         if (hold == 0) begin
            btn  = $urandom_range(0, 1);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(1, 3);
         end
         hold--;
         if ($urandom_range(0, 7) == 0) sw = $urandom;
         case ($urandom_range(0, 2))
            0:       a = A_DATA;
            1:       a = A_STAT;
            default: a = $urandom;
         endcase
         cycle(a, $urandom_range(0, 3) == 0);
      end
      rst = 1'b0;
      cycle(A_STAT, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain queue has %0d entries exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
